// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM dimmer and its prescaler.
package led_pkg;

    localparam int DUTY_W     = 32'd8;
    localparam int ADDR_W     = 32'd5;
    localparam int PRESCALE_W = 32'd16;

    localparam logic [ADDR_W-1:0] DUTY0    = 5'd0;
    localparam logic [ADDR_W-1:0] DUTY1    = 5'd1;
    localparam logic [ADDR_W-1:0] DUTY2    = 5'd2;
    localparam logic [ADDR_W-1:0] DUTY3    = 5'd3;
    localparam logic [ADDR_W-1:0] PRESCALE = 5'd4;
    localparam logic [ADDR_W-1:0] CTRL     = 5'd5;
    localparam logic [ADDR_W-1:0] STATUS   = 5'd6;

    localparam logic [DUTY_W-1:0] PWM_MAX    = 8'd254;
    localparam logic [DUTY_W-1:0] DUTY_RESET = 8'hFF;

    typedef struct packed {
        logic       bypass;
        logic [3:0] enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{bypass: 1'b0, enable: 4'hF};

    // Duty registers sit at addresses 0..N_CH-1, one per channel.
    function automatic logic duty_sel(input logic [ADDR_W-1:0] addr, input int unsigned ch);
        return (addr == ADDR_W'(ch));
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable tick generator: one-cycle tick every (prescale + 1) clocks.
// Shared between the dimmer and the blink engine.
module led_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] prescale,
    output logic        tick
);
    import led_pkg::*;

    logic [PRESCALE_W-1:0] pcnt_r;
    logic                  tick_s;

    // A count already past a freshly shrunk limit ticks at once and restarts, so it never runs away
    assign tick_s = (pcnt_r >= prescale);

    // Prescale counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_r <= 16'd0;
        end else if (tick_s) begin
            pcnt_r <= 16'd0;
        end else begin
            pcnt_r <= pcnt_r + 16'd1;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/led_pwm_dimmer.sv
// LED PWM dimmer: gates an upstream blink pattern with per-channel duty-cycle PWM.
// Duty updates are double-buffered and take effect only at the PWM period wrap.
module led_pwm_dimmer #(
    parameter int N_CH   = 32'd4,
    parameter int DUTY_W = 32'd8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout
);
    import led_pkg::*;

    logic                  wr_en_s;
    logic                  tick_s;
    logic                  wrap_s;
    logic [15:0]           prescale_r;
    ctrl_t                 ctrl_r;
    logic [DUTY_W-1:0]     pwm_cnt_r;
    logic [DUTY_W-1:0]     shadow_s [N_CH];
    logic [N_CH-1:0]       dout_next_s;
    logic [N_CH-1:0]       dout_r;
    logic [3:0]            din4_s;
    logic [31:0]           rd_data_s;
    logic                  unused_s;

    assign wr_en_s  = cs & write;
    assign wrap_s   = tick_s & (pwm_cnt_r == DUTY_W'(PWM_MAX));
    assign din4_s   = 4'(din);
    // The read strobe has no side effects and the upper write-data bits map to nothing
    assign unused_s = ^{read, wr_data[31:16]};

    // Prescale and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_r <= 16'd0;
            ctrl_r     <= CTRL_RESET;
        end else if (wr_en_s) begin
            case (addr)
                PRESCALE: prescale_r <= wr_data[15:0];
                CTRL:     ctrl_r     <= ctrl_t'(wr_data[4:0]);
                default: begin
                    prescale_r <= prescale_r;
                    ctrl_r     <= ctrl_r;
                end
            endcase
        end else begin
            prescale_r <= prescale_r;
            ctrl_r     <= ctrl_r;
        end
    end

    led_tick_gen u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale_r),
        .tick     (tick_s)
    );

    // PWM phase counter: 0..PWM_MAX, so the period is PWM_MAX+1 ticks and duty FF is solid on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_r <= {DUTY_W{1'b0}};
        end else if (wrap_s) begin
            pwm_cnt_r <= {DUTY_W{1'b0}};
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + DUTY_W'(1'b1);
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [DUTY_W-1:0] shadow_r;
        logic [DUTY_W-1:0] active_r;
        logic              pwm_on_s;

        // Shadow takes bus writes; the active copy follows it only at wrap, using the pre-write shadow
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                shadow_r <= DUTY_W'(DUTY_RESET);
                active_r <= DUTY_W'(DUTY_RESET);
            end else begin
                if (wr_en_s && duty_sel(addr, ch)) begin
                    shadow_r <= wr_data[DUTY_W-1:0];
                end else begin
                    shadow_r <= shadow_r;
                end
                if (wrap_s) begin
                    active_r <= shadow_r;
                end else begin
                    active_r <= active_r;
                end
            end
        end

        assign pwm_on_s        = (pwm_cnt_r < active_r);
        assign shadow_s[ch]    = shadow_r;
        assign dout_next_s[ch] = ctrl_r.bypass ? din[ch]
                                               : (din[ch] & ctrl_r.enable[ch] & pwm_on_s);
    end

    // Registered LED drive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r <= {N_CH{1'b0}};
        end else begin
            dout_r <= dout_next_s;
        end
    end

    assign dout = dout_r;

    // Register read mux; combinational, so a same-cycle write is not yet visible
    always_comb begin
        rd_data_s = 32'd0;
        case (addr)
            PRESCALE: rd_data_s = {16'd0, prescale_r};
            CTRL:     rd_data_s = {27'd0, ctrl_r};
            STATUS:   rd_data_s = {16'd0, 8'(pwm_cnt_r), 4'd0, din4_s};
            default:  rd_data_s = 32'd0;
        endcase
        for (int ch = 0; ch < N_CH; ch++) begin
            if (duty_sel(addr, ch)) begin
                rd_data_s = 32'(shadow_s[ch]);
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Scoreboard bench for led_pwm_dimmer: a behavioural model predicts rd_data and dout,
// monitors compare whenever the DUT presents them.
module tb_led_pwm_dimmer;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  din;
    logic [3:0]  dout;

    led_pwm_dimmer #(.N_CH(4), .DUTY_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd_q[$];
    logic [3:0]  dout_q[$];

    // Behavioural model state
    int       m_shadow[4];
    int       m_active[4];
    int       m_prescale;
    int       m_pcnt;
    int       m_pwm;
    bit       m_bypass;
    bit [3:0] m_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 255;
            m_active[i] = 255;
        end
        m_prescale = 0;
        m_pcnt     = 0;
        m_pwm      = 0;
        m_bypass   = 1'b0;
        m_en       = 4'hF;
    endfunction

    function automatic logic [31:0] model_read(input int a, input logic [3:0] d);
        logic [31:0] v;
        v = 32'd0;
        if (a < 4)       v = m_shadow[a];
        else if (a == 4) v = m_prescale;
        else if (a == 5) v = {27'd0, m_bypass, m_en};
        else if (a == 6) v = (m_pwm * 256) + d;
        return v;
    endfunction

    // Predicts dout after the coming edge, then advances the model across that edge
    function automatic logic [3:0] model_step(input bit c, input bit w, input int a,
                                              input logic [31:0] data, input logic [3:0] d);
        logic [3:0] e;
        bit tick;
        tick = (m_pcnt >= m_prescale);
        for (int ch = 0; ch < 4; ch++)
            e[ch] = m_bypass ? d[ch] : (d[ch] & m_en[ch] & (m_pwm < m_active[ch]));
        if (tick) begin
            m_pcnt = 0;
            if (m_pwm == 254) begin
                m_pwm    = 0;
                m_active = m_shadow;
            end else begin
                m_pwm++;
            end
        end else begin
            m_pcnt++;
        end
        if (c && w) begin
            if (a < 4) m_shadow[a] = int'(data[7:0]);
            else if (a == 4) m_prescale = int'(data[15:0]);
            else if (a == 5) begin
                m_bypass = data[4];
                m_en     = data[3:0];
            end
        end
        return e;
    endfunction

    // Called at posedge+2: drives one bus cycle, pushes expectations, returns at the next posedge+2
    task automatic cycle(input bit c, input bit r, input bit w, input int a,
                         input logic [31:0] data, input logic [3:0] d);
        cs      = c;
        read    = r;
        write   = w;
        addr    = a[4:0];
        wr_data = data;
        din     = d;
        if (c && r) rd_q.push_back(model_read(a, d));
        dout_q.push_back(model_step(c, w, a, data, d));
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic [3:0] d);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 32'd0, d);
    endtask

    task automatic check_reset_state(input string tag);
        cs    = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        din   = 4'h5;
        #1 check({tag, "_dout"}, {28'd0, dout}, 32'd0);
        addr = 5'd0; #1 check({tag, "_duty0"}, rd_data, 32'hFF);
        addr = 5'd2; #1 check({tag, "_duty2"}, rd_data, 32'hFF);
        addr = 5'd4; #1 check({tag, "_prescale"}, rd_data, 32'h0);
        addr = 5'd5; #1 check({tag, "_ctrl"}, rd_data, 32'h0F);
        addr = 5'd6; #1 check({tag, "_status"}, rd_data, 32'h5);
        addr = 5'd7; #1 check({tag, "_addr7"}, rd_data, 32'h0);
    endtask

    // Read-data monitor: rd_data is combinational, compared mid-cycle whenever a read is presented
    always @(negedge clk) begin
        if (reset && cs && read) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_q_empty actual=%h required=none", rd_data);
            end else begin
                check("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    // Output monitor: compares the registered drive just after each edge
    always @(posedge clk) begin
        #1;
        if (dout_q.size() != 0) check("dout", {28'd0, dout}, {28'd0, dout_q.pop_front()});
    end

    initial begin
        int hi0;
        int hi1;
        int n;
        reset   = 1'b0;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'd0;
        din     = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("por");
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Defaults: solid on, reads of duty0 give FF
        idle(20, 4'hF);
        cycle(1'b1, 1'b1, 1'b0, 0, 32'd0, 4'hF);

        // duty0 = 64 at prescale 0: 64 high clocks out of every 255
        cycle(1'b1, 1'b0, 1'b1, 0, 32'd64, 4'hF);
        idle(300, 4'hF);
        hi0 = 0;
        hi1 = 0;
        for (int i = 0; i < 255; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 0, 32'd0, 4'hF);
            hi0 += int'(dout[0]);
            hi1 += int'(dout[1]);
        end
        check("duty64_high_clks", hi0, 32'd64);
        check("duty255_high_clks", hi1, 32'd255);

        // prescale 9, duty1 = 128: 1280 high clocks per 2550-clock period
        cycle(1'b1, 1'b0, 1'b1, 4, 32'd9, 4'hF);
        cycle(1'b1, 1'b1, 1'b1, 1, 32'd128, 4'hF);
        for (int i = 0; i < 2600; i++) cycle(1'b1, 1'b1, 1'b0, 6, 32'd0, 4'hF);
        hi1 = 0;
        for (int i = 0; i < 2550; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 0, 32'd0, 4'hF);
            hi1 += int'(dout[1]);
        end
        check("duty128_high_clks", hi1, 32'd1280);

        // Shrink prescale below the running count, then duty2 255 -> 0 mid-period
        cycle(1'b1, 1'b0, 1'b1, 4, 32'd0, 4'hF);
        idle(100, 4'hF);
        cycle(1'b1, 1'b1, 1'b1, 2, 32'd0, 4'hF);
        idle(600, 4'hF);

        // Bypass with toggling din, then resume PWM and read the phase
        cycle(1'b1, 1'b0, 1'b1, 5, 32'h10, 4'hF);
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b0, 6, 32'd0, (i % 2 == 0) ? 4'hF : 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 5, 32'h0F, 4'hF);
        cycle(1'b1, 1'b1, 1'b0, 6, 32'd0, 4'hF);
        idle(300, 4'hF);

        // Randomized bus traffic and din
        for (int i = 0; i < 3000; i++) begin
            int          a;
            logic [31:0] dat;
            bit          c;
            bit          r;
            bit          w;
            a   = int'($urandom_range(0, 9));
            c   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 1) != 0);
            w   = ($urandom_range(0, 3) == 0);
            dat = $urandom;
            if (a == 4) dat = ($urandom_range(0, 15) == 0) ? $urandom_range(20, 300) : $urandom_range(0, 3);
            cycle(c, r, w, a, dat, 4'($urandom));
        end

        // Mid-period reset with a pending shadow write, near pwm_cnt 100
        cycle(1'b1, 1'b0, 1'b1, 4, 32'd0, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 5, 32'h0F, 4'hF);
        n = 0;
        while (m_pwm != 99 && n < 2000) begin
            cycle(1'b1, 1'b1, 1'b0, 6, 32'd0, 4'hF);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL pwm100_timeout actual=%0d required=99", m_pwm);
        end
        cycle(1'b1, 1'b1, 1'b1, 2, 32'h12, 4'hF);
        reset = 1'b0;
        model_reset();
        check_reset_state("mid");
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 7, 32'hFFFF_FFFF, 4'hF);
        cycle(1'b1, 1'b1, 1'b1, 6, 32'hFFFF_FFFF, 4'hF);
        for (int a = 0; a < 10; a++) cycle(1'b1, 1'b1, 1'b0, a, 32'd0, 4'hA);
        idle(300, 4'hF);

        check("queues_drained", rd_q.size() + dout_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pwm_dimmer.md
LED_PWM_DIMMER -- requirements
Module: led_pwm_dimmer

Interface
REQ-001 Parameter N_CH, default 4: number of LED channels.
REQ-002 Parameter DUTY_W, default 8: duty and PWM counter width.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cs  input  1  slot select; a bus access is valid only when cs=1.
REQ-006 read  input  1  read strobe; has no side effects.
REQ-007 write  input  1  write strobe; the register is written on the clk edge where cs&write=1.
REQ-008 addr  input  5  register index.
REQ-009 wr_data  input  32  write data.
REQ-010 rd_data  output  32  read data; combinational from addr.
REQ-011 din  input  N_CH  blink pattern from the upstream led_blink dout.
REQ-012 dout  output  N_CH  dimmed LED drive to pins; registered.

Function
REQ-013 Register map: addr 0..3 = duty[ch] (wr_data[7:0]); addr 4 = prescale (wr_data[15:0]); addr 5 = ctrl (bit4 bypass, bits3:0 enable); addr 6 = status, read-only, returns {pwm_cnt[7:0] in bits15:8, din in bits3:0}.
REQ-014 Writes to addr 6 or addr >= 7 are ignored; reads of addr >= 7 return 0; unused rd_data bits read 0.
REQ-015 Duty writes go to shadow[ch]; active_duty[ch] loads from shadow[ch] only on the cycle the PWM counter wraps, so no partial PWM period is produced.
REQ-016 Prescaler: a 16-bit counter pcnt generates tick=1 when pcnt >= prescale, then clears to 0; otherwise pcnt increments. prescale=0 gives tick on every cycle.
REQ-017 A prescale write smaller than the current pcnt forces a tick on the next cycle, with no counter runaway.
REQ-018 PWM counter pwm_cnt advances only on tick and counts 0..254, wrapping 254->0; the period is 255 ticks.
REQ-019 Compare: pwm_on[ch] = (pwm_cnt < active_duty[ch]). Duty 0 is always off; duty 255 is always on.
REQ-020 dout[ch] is registered: next = bypass ? din[ch] : (din[ch] & enable[ch] & pwm_on[ch]). Latency from din to dout is 1 clk.
REQ-021 When bypass=1, PWM and prescaler counters keep running, so leaving bypass does not cause a phase jump.
REQ-022 A simultaneous duty write and wrap loads the old shadow into active_duty; the new value takes effect at the next wrap.
REQ-023 A read and a write to the same address in the same cycle return the pre-write value.

Reset
REQ-024 Asserting reset (low) immediately forces: dout=0, pcnt=0, pwm_cnt=0, shadow=active_duty=8'hFF, prescale=0, enable=4'hF, bypass=0.
REQ-025 Reset asserted mid-period discards all pending shadow writes.
REQ-026 Leaving reset synchronously to clk: the first tick occurs on the first clk edge after reset is released.

Structure
REQ-027 Package led_pkg holds the register address constants (DUTY0..3, PRESCALE, CTRL, STATUS), DUTY_W, PWM_MAX=254, and a ctrl_t packed struct {bypass, enable[3:0]}.
REQ-028 The prescaler is a separate sub-module, led_tick_gen (ports: clk, reset, prescale, tick), reusable by led_blink.
REQ-029 The per-channel compare and output register are generated, with no per-channel copies written out by hand.

Verification
REQ-030 Reset then din=4'hF with default registers -> dout=4'hF from the second clk after reset is released; rd_data at addr 0 = 32'hFF.
REQ-031 prescale=0, duty0=8'd64, din[0]=1 -> dout[0] high for exactly 64 of every 255 clks; period measured as 255 clks.
REQ-032 prescale=9, duty1=8'd128 -> dout[1] high for 1280 clks, low for 1270 clks; tick is observed every 10 clks.
REQ-033 Write duty2=0 mid-period, with the previous value 255 -> dout[2] stays high until the next wrap, then stays low; no short pulse appears.
REQ-034 ctrl=5'h10 (bypass) with din toggling every clk -> dout equals din delayed by 1 clk; write ctrl=5'h0F -> PWM resumes at the current pwm_cnt, read via addr 6.
REQ-035 Drop reset while pwm_cnt=100 and a shadow write is pending -> all registers return to reset values within the same cycle; addr 7 reads 0 and writes to it have no effect.
